// File: rtl/frame_reader.sv
// frame_reader
//   Drains one frame of DEPTH signed samples from the read side of a
//   ping-pong buffer and forwards them on a valid/ready stream. It also
//   accumulates a wrapping signed frame sum and counts start pulses that
//   arrive while a frame is still in progress.
//
//   Optional feature: define FRAME_READER_PEAK_EN to add peak_o, the largest
//   |sample| of the last completed frame. The most-negative sample's
//   magnitude saturates to 2^(WIDTH-1)-1.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   buffer_ready_i   one-cycle pulse: a full frame is available upstream
//   read_data_i      signed sample from the buffer read side
//   read_valid_i     read_data_i valid
//   read_ready_o     sample accepted this cycle when read_valid_i is high
//   m_data_o         signed output sample
//   m_valid_o        m_data_o valid
//   m_ready_i        downstream accepts m_data_o
//   m_last_o         marks the final sample of a frame
//   frame_done_o     one-cycle pulse when the final sample leaves the block
//   frame_sum_o      signed sum of the last completed frame
//   busy_o           high whenever a frame is in progress
//   missed_frames_o  saturating count of ignored buffer_ready_i pulses
//   peak_o           (FRAME_READER_PEAK_EN only) peak magnitude of last frame
//
// state | meaning
// IDLE  | waiting for buffer_ready_i
// DRAIN | accepting samples from the buffer
// FLUSH | last sample held at the output, waiting for downstream
module frame_reader #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int SUM_WIDTH = WIDTH + $clog2(DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        buffer_ready_i,
  input  logic signed [WIDTH-1:0]     read_data_i,
  input  logic                        read_valid_i,
  output logic                        read_ready_o,
  output logic signed [WIDTH-1:0]     m_data_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic                        m_last_o,
  output logic                        frame_done_o,
  output logic signed [SUM_WIDTH-1:0] frame_sum_o,
  output logic                        busy_o,
  output logic [7:0]                  missed_frames_o
`ifdef FRAME_READER_PEAK_EN
  ,
  output logic [WIDTH-1:0]            peak_o
`endif
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]            cnt_q;
  logic signed [SUM_WIDTH-1:0] sum_q;
  logic                        accept;
  logic                        start;
  logic                        frame_end;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    read_ready_o = 1'b0;
    busy_o       = 1'b0;
    start        = 1'b0;
    frame_end    = 1'b0;
    case (state_q)
      IDLE: begin
        start = buffer_ready_i;
        if (buffer_ready_i) state_d = DRAIN;
      end
      DRAIN: begin
        busy_o       = 1'b1;
        // Output register is free, or it is being emptied this cycle.
        read_ready_o = !m_valid_o || m_ready_i;
        if (read_valid_i && read_ready_o && (cnt_q == CNT_LAST)) state_d = FLUSH;
      end
      FLUSH: begin
        busy_o    = 1'b1;
        frame_end = m_valid_o && m_ready_i;
        if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = read_valid_i && read_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q           <= '0;
      sum_q           <= '0;
      m_data_o        <= '0;
      m_valid_o       <= 1'b0;
      m_last_o        <= 1'b0;
      frame_done_o    <= 1'b0;
      frame_sum_o     <= '0;
      missed_frames_o <= '0;
    end else begin
      frame_done_o <= 1'b0;

      if (start) begin
        cnt_q <= '0;
        sum_q <= '0;
      end else if (accept) begin
        // DEPTH is a power of two, so the counter wraps back to zero by itself.
        cnt_q <= cnt_q + 1'b1;
        sum_q <= sum_q + SUM_WIDTH'(read_data_i);
      end

      if (accept) begin
        m_data_o  <= read_data_i;
        m_valid_o <= 1'b1;
        m_last_o  <= (cnt_q == CNT_LAST);
      end else if (m_valid_o && m_ready_i) begin
        m_valid_o <= 1'b0;
        m_last_o  <= 1'b0;
      end

      if (frame_end) begin
        frame_done_o <= 1'b1;
        frame_sum_o  <= sum_q;
      end

      // A start request during a frame, including the FLUSH->IDLE cycle, is dropped.
      if (buffer_ready_i && (state_q != IDLE) && (missed_frames_o != 8'hFF)) begin
        missed_frames_o <= missed_frames_o + 8'd1;
      end
    end
  end

`ifdef FRAME_READER_PEAK_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic [WIDTH-1:0] abs_sample;
  logic [WIDTH-1:0] peak_q;

  always_comb begin
    abs_sample = read_data_i;
    if (read_data_i[WIDTH-1]) begin
      // The most-negative value has no positive counterpart.
      if (read_data_i[WIDTH-2:0] == '0) abs_sample = MAX_POS;
      else                              abs_sample = -read_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      peak_q <= '0;
      peak_o <= '0;
    end else begin
      if (start) begin
        peak_q <= '0;
      end else if (accept && (abs_sample > peak_q)) begin
        peak_q <= abs_sample;
      end
      if (frame_end) peak_o <= peak_q;
    end
  end
`endif

endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader
//   Self-checking bench for frame_reader with WIDTH=16, DEPTH=4.
//   Output samples and frame sums are predicted when stimulus is driven and
//   compared in order when the block produces them.
//   peak_o is connected and checked when FRAME_READER_PEAK_EN is defined.
module tb_frame_reader;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int SUM_WIDTH = WIDTH + $clog2(DEPTH);

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  logic                        buffer_ready_i;
  logic signed [WIDTH-1:0]     read_data_i;
  logic                        read_valid_i;
  logic                        read_ready_o;
  logic signed [WIDTH-1:0]     m_data_o;
  logic                        m_valid_o;
  logic                        m_ready_i;
  logic                        m_last_o;
  logic                        frame_done_o;
  logic signed [SUM_WIDTH-1:0] frame_sum_o;
  logic                        busy_o;
  logic [7:0]                  missed_frames_o;
`ifdef FRAME_READER_PEAK_EN
  logic [WIDTH-1:0]            peak_o;
`endif

  frame_reader #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .buffer_ready_i  (buffer_ready_i),
    .read_data_i     (read_data_i),
    .read_valid_i    (read_valid_i),
    .read_ready_o    (read_ready_o),
    .m_data_o        (m_data_o),
    .m_valid_o       (m_valid_o),
    .m_ready_i       (m_ready_i),
    .m_last_o        (m_last_o),
    .frame_done_o    (frame_done_o),
    .frame_sum_o     (frame_sum_o),
    .busy_o          (busy_o),
    .missed_frames_o (missed_frames_o)
`ifdef FRAME_READER_PEAK_EN
    ,
    .peak_o          (peak_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   sum_q[$];
  exp_t mon_e;
  int   done_cnt = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", m_data_o, mon_e.data);
          check("out_last", m_last_o, mon_e.last);
        end
      end
      if (frame_done_o) begin
        done_cnt++;
        if (sum_q.size() == 0) check("done_unexpected", 1, 0);
        else                   check("frame_sum", frame_sum_o, sum_q.pop_front());
      end
    end
  end

  // All driver tasks are entered and left 1 time unit after a rising edge.
  task automatic start_frame(input int exp_sum);
    sum_q.push_back(exp_sum);
    buffer_ready_i = 1'b1;
    @(posedge clk_i); #1;
    buffer_ready_i = 1'b0;
  endtask

  task automatic send(input int x, input bit last);
    bit ok = 1'b0;
    exp_q.push_back('{x, last});
    read_data_i  = 16'(x);
    read_valid_i = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_i);
      if (read_ready_o) ok = 1'b1;
    end
    @(posedge clk_i); #1;
    read_valid_i = 1'b0;
    if (!ok) begin
      check("accept_timeout", 0, 1);
    end else begin
      check("lat_valid", m_valid_o, 1);
      check("lat_data", m_data_o, x);
    end
  endtask

  task automatic send_frame(input int s0, input int s1, input int s2, input int s3);
    send(s0, 1'b0);
    send(s1, 1'b0);
    send(s2, 1'b0);
    send(s3, 1'b1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 20 && done_cnt < target; i++) @(posedge clk_i);
    #1;
    check("done_count", done_cnt, target);
  endtask

  task automatic pulse_ready(input int n);
    for (int i = 0; i < n; i++) begin
      buffer_ready_i = 1'b1;
      @(posedge clk_i); #1;
      buffer_ready_i = 1'b0;
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    rst_i          = 1'b1;
    buffer_ready_i = 1'b0;
    read_data_i    = '0;
    read_valid_i   = 1'b0;
    m_ready_i      = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", m_valid_o, 0);
    check("rst_ready", read_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_missed", missed_frames_o, 0);
    check("rst_sum", frame_sum_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Basic frame with an always-ready sink.
    start_frame(10);
    check("busy_drain", busy_o, 1);
    send_frame(1, 2, 3, 4);
    wait_done(1);
    check("done_pulse", frame_done_o, 0);
    check("idle_busy", busy_o, 0);
    check("idle_valid", m_valid_o, 0);
`ifdef FRAME_READER_PEAK_EN
    check("peak_basic", peak_o, 4);
`endif

    // Downstream stall after the first output.
    start_frame(-32764);
    send(-32768, 1'b0);
    m_ready_i    = 1'b0;
    read_data_i  = -16'sd1;
    read_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("stall_ready", read_ready_o, 0);
      check("stall_valid", m_valid_o, 1);
      check("stall_data", m_data_o, -32768);
    end
    @(posedge clk_i); #1;
    m_ready_i = 1'b1;
    send(-1, 1'b0);
    send(5, 1'b0);
    send(0, 1'b1);
    wait_done(2);
`ifdef FRAME_READER_PEAK_EN
    check("peak_sat", peak_o, 32767);
`endif
    repeat (4) @(posedge clk_i);
    #1;
    check("sum_hold", frame_sum_o, -32764);

    // Start requests during a frame are counted, not honoured.
    start_frame(10);
    send(1, 1'b0);
    pulse_ready(3);
    check("missed_3", missed_frames_o, 3);
    send(2, 1'b0);
    send(3, 1'b0);
    send(4, 1'b1);
    wait_done(3);
    check("missed_keep", missed_frames_o, 3);
    start_frame(26);
    send(5, 1'b0);
    pulse_ready(260);
    check("missed_sat", missed_frames_o, 255);
    send(6, 1'b0);
    send(7, 1'b0);
    send(8, 1'b1);
    wait_done(4);

    // Valid data while idle is not taken.
    read_data_i  = 16'sd99;
    read_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("idle_no_ready", read_ready_o, 0);
      check("idle_no_valid", m_valid_o, 0);
    end
    @(posedge clk_i); #1;
    read_valid_i = 1'b0;

    // Reset in the middle of a frame.
    start_frame(0);
    send(3, 1'b0);
    send(9, 1'b0);
    rst_i = 1'b1;
    #1;
    check("abort_valid", m_valid_o, 0);
    check("abort_data", m_data_o, 0);
    check("abort_last", m_last_o, 0);
    check("abort_ready", read_ready_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_sum", frame_sum_o, 0);
    check("abort_missed", missed_frames_o, 0);
    exp_q.delete();
    sum_q.delete();
    d = done_cnt;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("abort_no_done", done_cnt, d);
    start_frame(28);
    send_frame(7, 7, 7, 7);
    wait_done(d + 1);

    // Back-to-back frames: next start lands while frame_done_o is high.
    start_frame(-2);
    send_frame(1, -2, 3, -4);
    @(posedge clk_i); #1;
    check("b2b_done", frame_done_o, 1);
    start_frame(251);
    send_frame(100, 200, -50, 1);
    wait_done(d + 3);
    check("b2b_missed", missed_frames_o, 0);

    // A start pulse in the FLUSH->IDLE cycle is dropped and counted.
    start_frame(4);
    send_frame(1, 1, 1, 1);
    buffer_ready_i = 1'b1;
    @(posedge clk_i); #1;
    buffer_ready_i = 1'b0;
    check("flush_done", frame_done_o, 1);
    check("flush_missed", missed_frames_o, 1);
    @(posedge clk_i); #1;
    check("flush_no_start", busy_o, 0);
    wait_done(d + 4);

    repeat (3) @(posedge clk_i);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter WIDTH, default 32, sample width in bits (signed).
REQ-002 Parameter DEPTH, default 16, samples per frame; SHALL be a power of two, >= 2.
REQ-003 Parameter SUM_WIDTH, default WIDTH+$clog2(DEPTH), frame-sum width.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 buffer_ready_i  in  1  one-cycle pulse: a full frame is available upstream.
REQ-007 read_data_i  in  WIDTH  signed sample from the ping-pong buffer read side.
REQ-008 read_valid_i  in  1  read_data_i valid.
REQ-009 read_ready_o  out  1  block accepts read_data_i this cycle.
REQ-010 m_data_o  out  WIDTH  signed output sample.
REQ-011 m_valid_o  out  1  m_data_o valid.
REQ-012 m_ready_i  in  1  downstream accepts m_data_o.
REQ-013 m_last_o  out  1  high with the final sample of a frame.
REQ-014 frame_done_o  out  1  one-cycle pulse when the last sample leaves the block.
REQ-015 frame_sum_o  out  SUM_WIDTH  signed sum of the last completed frame.
REQ-016 busy_o  out  1  high in any state other than IDLE.
REQ-017 missed_frames_o  out  8  saturating count of ignored buffer_ready_i pulses.

Function
REQ-018 FSM states SHALL be IDLE, DRAIN, FLUSH; reset state IDLE.
REQ-019 IDLE -> DRAIN on buffer_ready_i=1; sample counter and running sum cleared on the same edge.
REQ-020 read_ready_o SHALL equal (state==DRAIN) && (!m_valid_o || m_ready_i); combinational, no dependency on read_valid_i.
REQ-021 Accept = read_valid_i && read_ready_o; on accept, m_data_o <= read_data_i and m_valid_o <= 1 at the next edge (latency 1 cycle).
REQ-022 m_data_o, m_last_o SHALL hold stable while m_valid_o && !m_ready_i.
REQ-023 m_valid_o SHALL clear after m_valid_o && m_ready_i unless a new accept occurs in the same cycle.
REQ-024 Running sum SHALL add sign-extended read_data_i on each accept; wrap modulo 2^SUM_WIDTH, no saturation.
REQ-025 On accept of sample DEPTH-1 (zero-based), m_last_o <= 1 with that sample and DRAIN -> FLUSH.
REQ-026 FLUSH -> IDLE when m_valid_o && m_ready_i; same edge: frame_done_o <= 1 for one cycle, frame_sum_o <= running sum.
REQ-027 frame_sum_o SHALL hold until the next frame completes.
REQ-028 buffer_ready_i in DRAIN or FLUSH SHALL be ignored and increment missed_frames_o, saturating at 255.
REQ-029 buffer_ready_i in the FLUSH->IDLE transition cycle counts as missed; no back-to-back start.
REQ-030 read_valid_i outside DRAIN SHALL be ignored (read_ready_o=0).

Reset
REQ-031 rst_i=1 SHALL immediately force: state IDLE, read_ready_o=0, m_valid_o=0, m_data_o=0, m_last_o=0, frame_done_o=0, frame_sum_o=0, busy_o=0, missed_frames_o=0, counter and running sum 0.
REQ-032 Reset mid-frame SHALL abort the frame with no frame_done_o pulse; the partial sum is discarded.

Configuration
REQ-033 Macro FRAME_READER_PEAK_EN SHALL gate a peak detector.
REQ-034 Defined: output peak_o [WIDTH-1:0] unsigned = max |sample| of last completed frame, updated with frame_sum_o; |most-negative| saturates to 2^(WIDTH-1)-1; reset 0.
REQ-035 Undefined: peak_o port and peak logic absent; all other behaviour identical.

Verification (WIDTH=16, DEPTH=4)
REQ-036 buffer_ready_i pulse, samples 1,2,3,4 with m_ready_i=1 -> m_data_o 1,2,3,4 one cycle after each accept, m_last_o with 4, frame_done_o once, frame_sum_o=10.
REQ-037 Samples -32768,-1,5,0, m_ready_i low 3 cycles after first output -> read_ready_o=0 during stall, m_data_o holds -32768, frame_sum_o=-32764 (peak_o=32767 with macro).
REQ-038 Three buffer_ready_i pulses during DRAIN -> missed_frames_o=3; frame completes normally; 260 missed pulses -> 255.
REQ-039 rst_i asserted after 2 accepts -> outputs zero that cycle, no frame_done_o, next frame 7,7,7,7 gives frame_sum_o=28.
REQ-040 read_valid_i=1 in IDLE with no buffer_ready_i -> read_ready_o=0, m_valid_o stays 0.
REQ-041 Two frames back to back (second buffer_ready_i one cycle after frame_done_o) -> both complete, second frame_sum_o correct, missed_frames_o=0.
